// File: rtl/pc_sequencer.sv
// Sequencer that drives the program counter's load/inc/address command triple
// and keeps a hardware return-address stack for call/return.
module pc_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic [ADDR_W-1:0] target,
    input  logic              err_clr,
    output logic              cmd_ready,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_address,
    output logic [CNT_W-1:0]  stack_depth,
    output logic              err_ovf,
    output logic              err_unf
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] C_STEP    = 3'b001;
    localparam logic [2:0] C_JUMP    = 3'b010;
    localparam logic [2:0] C_CALL    = 3'b011;
    localparam logic [2:0] C_RET     = 3'b100;
    localparam logic [2:0] C_RESTART = 3'b101;

    typedef enum logic [1:0] {CLR, RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] stack [DEPTH];
    logic [CNT_W-1:0]  depth;
    logic [IDX_W-1:0]  wr_idx, top_idx;
    logic              accept, push, pop, flush, set_ovf, set_unf, clr_err;
    logic              full, empty;

    assign wr_idx      = IDX_W'(depth);
    assign top_idx     = IDX_W'(depth - 1'b1);
    assign full        = (depth == CNT_W'(DEPTH));
    assign empty       = (depth == '0);
    assign cmd_ready   = rst_n && (state == RUN);
    assign accept      = cmd_valid && cmd_ready;
    assign stack_depth = depth;

    always_comb begin
        state_nxt  = state;
        pc_load    = 1'b1;
        pc_inc     = 1'b1;
        pc_address = '0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        clr_err    = 1'b0;
        if (!rst_n) begin
            pc_load = 1'b0;
            pc_inc  = 1'b0;
        end else begin
            case (state)
                CLR: begin
                    pc_load   = 1'b0;
                    pc_inc    = 1'b0;
                    state_nxt = RUN;
                end
                RUN: if (accept) begin
                    case (cmd)
                        C_STEP: pc_load = 1'b0;
                        C_JUMP: begin
                            pc_inc     = 1'b0;
                            pc_address = target;
                        end
                        C_CALL: begin
                            if (full) begin
                                set_ovf   = 1'b1;
                                state_nxt = HALT;
                            end else begin
                                push       = 1'b1;
                                pc_inc     = 1'b0;
                                pc_address = target;
                            end
                        end
                        C_RET: begin
                            if (empty) begin
                                set_unf   = 1'b1;
                                state_nxt = HALT;
                            end else begin
                                pop        = 1'b1;
                                pc_inc     = 1'b0;
                                pc_address = stack[top_idx];
                            end
                        end
                        C_RESTART: begin
                            pc_load = 1'b0;
                            pc_inc  = 1'b0;
                            flush   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                HALT: if (err_clr) begin
                    state_nxt = CLR;
                    flush     = 1'b1;
                    clr_err   = 1'b1;
                end
                default: state_nxt = CLR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLR;
            depth   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush)     depth <= '0;
            else if (push) depth <= depth + 1'b1;
            else if (pop)  depth <= depth - 1'b1;
            if (clr_err) begin
                err_ovf <= 1'b0;
                err_unf <= 1'b0;
            end else begin
                if (set_ovf) err_ovf <= 1'b1;
                if (set_unf) err_unf <= 1'b1;
            end
        end
    end

    // Return address wraps naturally at the top of the address space.
    always_ff @(posedge clk) begin
        if (rst_n && push) stack[wr_idx] <= pc_in + 1'b1;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: driver pushes per-cycle expectations, a negedge monitor
// pops and compares them against the DUT and a behavioural program counter.
module tb_pc_sequencer;
    localparam logic [2:0] HLD = 3'd0, STP = 3'd1, JMP = 3'd2, CAL = 3'd3,
                           RET = 3'd4, RST = 3'd5, BAD = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, err_clr;
    logic [2:0]  cmd;
    logic [11:0] target, pc_address, pc;
    logic        cmd_ready, pc_load, pc_inc, err_ovf, err_unf;
    logic [3:0]  stack_depth;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q [$];
    string       nm_q  [$];

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(12), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc), .cmd_valid(cmd_valid), .cmd(cmd),
        .target(target), .err_clr(err_clr), .cmd_ready(cmd_ready),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_address(pc_address),
        .stack_depth(stack_depth), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    // Behavioural program counter obeying the load/inc encoding.
    initial pc = 12'h000;
    always @(posedge clk) begin
        case ({pc_load, pc_inc})
            2'b00:   pc <= 12'h000;
            2'b10:   pc <= pc_address;
            2'b01:   pc <= pc + 12'h001;
            default: pc <= pc;
        endcase
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [32:0] e, a;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = {pc_load, pc_inc, pc_address, stack_depth, err_ovf, err_unf, cmd_ready, pc};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got li=%b addr=%h dep=%0d ovf/unf=%b rdy=%b pc=%h, want li=%b addr=%h dep=%0d ovf/unf=%b rdy=%b pc=%h",
                         n, a[32:31], a[30:19], a[18:15], a[14:13], a[12], a[11:0],
                         e[32:31], e[30:19], e[18:15], e[14:13], e[12], e[11:0]);
            end
        end
    end

    task automatic cyc(input string nm, input bit r, input bit v, input logic [2:0] c,
                       input logic [11:0] tg, input bit ec, input logic [1:0] li,
                       input logic [11:0] ad, input logic [3:0] dp, input logic [1:0] er,
                       input bit rd, input logic [11:0] p);
        @(posedge clk);
        #1;
        rst_n = r; cmd_valid = v; cmd = c; target = tg; err_clr = ec;
        exp_q.push_back({li, ad, dp, er, rd, p});
        nm_q.push_back(nm);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = HLD; target = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        //   name       rst v  cmd  target  ec li     addr    dep er     rd pc
        cyc("reset",    0, 0, HLD, 12'h0,  0, 2'b00, 12'h0,  0, 2'b00, 0, 12'h000);
        cyc("clr",      1, 0, HLD, 12'h0,  0, 2'b00, 12'h0,  0, 2'b00, 0, 12'h000);
        cyc("step0",    1, 1, STP, 12'h0,  0, 2'b01, 12'h0,  0, 2'b00, 1, 12'h000);
        cyc("step1",    1, 1, STP, 12'h0,  0, 2'b01, 12'h0,  0, 2'b00, 1, 12'h001);
        cyc("step2",    1, 1, STP, 12'h0,  0, 2'b01, 12'h0,  0, 2'b00, 1, 12'h002);
        cyc("idle",     1, 0, STP, 12'h0,  0, 2'b11, 12'h0,  0, 2'b00, 1, 12'h003);
        cyc("jump",     1, 1, JMP, 12'h10, 0, 2'b10, 12'h10, 0, 2'b00, 1, 12'h003);
        cyc("call",     1, 1, CAL, 12'h200,0, 2'b10, 12'h200,0, 2'b00, 1, 12'h010);
        cyc("ret",      1, 1, RET, 12'h0,  0, 2'b10, 12'h011,1, 2'b00, 1, 12'h200);
        cyc("post_ret", 1, 0, HLD, 12'h0,  0, 2'b11, 12'h0,  0, 2'b00, 1, 12'h011);
        for (int pass = 0; pass < 2; pass++) begin
            cyc("jump1", 1, 1, JMP, 12'h001, 0, 2'b10, 12'h001, 0, 2'b00, 1,
                (pass == 0) ? 12'h011 : 12'h002);
            for (int k = 1; k <= 8; k++)
                cyc("nest_call", 1, 1, CAL, 12'(k + 1), 0, 2'b10, 12'(k + 1), 4'(k - 1),
                    2'b00, 1, 12'(k));
            if (pass == 0)
                for (int j = 0; j < 8; j++)
                    cyc("nest_ret", 1, 1, RET, 12'h0, 0, 2'b10, 12'(9 - j), 4'(8 - j),
                        2'b00, 1, (j == 0) ? 12'h009 : 12'(10 - j));
        end
        cyc("ovf_call", 1, 1, CAL, 12'h300,0, 2'b11, 12'h0,  8, 2'b00, 1, 12'h009);
        cyc("halt_ign", 1, 1, STP, 12'h0,  0, 2'b11, 12'h0,  8, 2'b10, 0, 12'h009);
        cyc("halt_clr", 1, 0, HLD, 12'h0,  1, 2'b11, 12'h0,  8, 2'b10, 0, 12'h009);
        cyc("clr_ovf",  1, 1, STP, 12'h0,  0, 2'b00, 12'h0,  0, 2'b00, 0, 12'h009);
        cyc("run_eclr", 1, 0, HLD, 12'h0,  1, 2'b11, 12'h0,  0, 2'b00, 1, 12'h000);
        cyc("unf_ret",  1, 1, RET, 12'h0,  0, 2'b11, 12'h0,  0, 2'b00, 1, 12'h000);
        cyc("halt_unf", 1, 1, RET, 12'h0,  0, 2'b11, 12'h0,  0, 2'b01, 0, 12'h000);
        cyc("halt_jmp", 1, 1, JMP, 12'h55, 0, 2'b11, 12'h0,  0, 2'b01, 0, 12'h000);
        cyc("unf_clr",  1, 0, HLD, 12'h0,  1, 2'b11, 12'h0,  0, 2'b01, 0, 12'h000);
        cyc("clr_unf",  1, 0, HLD, 12'h0,  0, 2'b00, 12'h0,  0, 2'b00, 0, 12'h000);
        cyc("jmp_fff",  1, 1, JMP, 12'hFFF,0, 2'b10, 12'hFFF,0, 2'b00, 1, 12'h000);
        cyc("call_wrap",1, 1, CAL, 12'h100,0, 2'b10, 12'h100,0, 2'b00, 1, 12'hFFF);
        cyc("ret_wrap", 1, 1, RET, 12'h0,  0, 2'b10, 12'h000,1, 2'b00, 1, 12'h100);
        cyc("call_a",   1, 1, CAL, 12'h050,0, 2'b10, 12'h050,0, 2'b00, 1, 12'h000);
        cyc("call_b",   1, 1, CAL, 12'h060,0, 2'b10, 12'h060,1, 2'b00, 1, 12'h050);
        cyc("call_c",   1, 1, CAL, 12'h070,0, 2'b10, 12'h070,2, 2'b00, 1, 12'h060);
        cyc("rst_mid",  0, 1, RET, 12'h0,  1, 2'b00, 12'h0,  3, 2'b00, 0, 12'h070);
        cyc("rst_clr",  1, 0, HLD, 12'h0,  0, 2'b00, 12'h0,  0, 2'b00, 0, 12'h000);
        cyc("call_r",   1, 1, CAL, 12'h020,0, 2'b10, 12'h020,0, 2'b00, 1, 12'h000);
        cyc("restart",  1, 1, RST, 12'h0,  0, 2'b00, 12'h0,  1, 2'b00, 1, 12'h020);
        cyc("bad_cmd",  1, 1, BAD, 12'h0,  0, 2'b11, 12'h0,  0, 2'b00, 1, 12'h000);
        cyc("final",    1, 0, HLD, 12'h0,  0, 2'b11, 12'h0,  0, 2'b00, 1, 12'h000);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
